// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 set-2 key decoder: FSM states, entry
// field positions and the scancodes the decoder treats specially.
package ps2_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_EMIT   = 2'd2
    } state_t;

    // Entry layout: {break, extended, code[7:0]}
    localparam int BREAK_BIT = 9;
    localparam int EXT_BIT   = 8;

    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_ALT    = 8'h11;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_SLASH  = 8'h4A;

    // Keyboard controller responses that never represent a key
    localparam logic [7:0] SC_ERR0   = 8'h00;
    localparam logic [7:0] SC_BAT_OK = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_RESEND = 8'hFE;
    localparam logic [7:0] SC_ERR1   = 8'hFF;

    function automatic logic is_ctrl_resp(input logic [7:0] code);
        return (code == SC_ERR0)  || (code == SC_BAT_OK) || (code == SC_ACK) ||
               (code == SC_RESEND) || (code == SC_ERR1);
    endfunction

endpackage

// File: rtl/ps2_keymap.sv
// Combinational set-2 to ASCII ROM for the non-extended key block.
// Each row holds the {unshifted, shifted} character pair; unmapped codes give 0.
module ps2_keymap (
    input  logic [7:0] code,
    input  logic       shift,
    output logic [7:0] ascii,
    output logic       is_letter
);

    logic [7:0] lower_c;
    logic [7:0] upper_c;

    // ROM lookup of the character pair for this code
    always_comb begin
        {lower_c, upper_c} = 16'h0000;
        unique case (code)
            8'h1C: {lower_c, upper_c} = "aA";
            8'h32: {lower_c, upper_c} = "bB";
            8'h21: {lower_c, upper_c} = "cC";
            8'h23: {lower_c, upper_c} = "dD";
            8'h24: {lower_c, upper_c} = "eE";
            8'h2B: {lower_c, upper_c} = "fF";
            8'h34: {lower_c, upper_c} = "gG";
            8'h33: {lower_c, upper_c} = "hH";
            8'h43: {lower_c, upper_c} = "iI";
            8'h3B: {lower_c, upper_c} = "jJ";
            8'h42: {lower_c, upper_c} = "kK";
            8'h4B: {lower_c, upper_c} = "lL";
            8'h3A: {lower_c, upper_c} = "mM";
            8'h31: {lower_c, upper_c} = "nN";
            8'h44: {lower_c, upper_c} = "oO";
            8'h4D: {lower_c, upper_c} = "pP";
            8'h15: {lower_c, upper_c} = "qQ";
            8'h2D: {lower_c, upper_c} = "rR";
            8'h1B: {lower_c, upper_c} = "sS";
            8'h2C: {lower_c, upper_c} = "tT";
            8'h3C: {lower_c, upper_c} = "uU";
            8'h2A: {lower_c, upper_c} = "vV";
            8'h1D: {lower_c, upper_c} = "wW";
            8'h22: {lower_c, upper_c} = "xX";
            8'h35: {lower_c, upper_c} = "yY";
            8'h1A: {lower_c, upper_c} = "zZ";
            8'h45: {lower_c, upper_c} = 16'h3029; // 0 )
            8'h16: {lower_c, upper_c} = 16'h3121; // 1 !
            8'h1E: {lower_c, upper_c} = 16'h3240; // 2 @
            8'h26: {lower_c, upper_c} = 16'h3323; // 3 #
            8'h25: {lower_c, upper_c} = 16'h3424; // 4 $
            8'h2E: {lower_c, upper_c} = 16'h3525; // 5 %
            8'h36: {lower_c, upper_c} = 16'h365E; // 6 ^
            8'h3D: {lower_c, upper_c} = 16'h3726; // 7 &
            8'h3E: {lower_c, upper_c} = 16'h382A; // 8 *
            8'h46: {lower_c, upper_c} = 16'h3928; // 9 (
            8'h29: {lower_c, upper_c} = 16'h2020; // space
            8'h5A: {lower_c, upper_c} = 16'h0D0D; // enter
            8'h66: {lower_c, upper_c} = 16'h0808; // backspace
            8'h0D: {lower_c, upper_c} = 16'h0909; // tab
            8'h76: {lower_c, upper_c} = 16'h1B1B; // escape
            8'h4E: {lower_c, upper_c} = 16'h2D5F; // - _
            8'h55: {lower_c, upper_c} = 16'h3D2B; // = +
            8'h54: {lower_c, upper_c} = 16'h5B7B; // [ {
            8'h5B: {lower_c, upper_c} = 16'h5D7D; // ] }
            8'h5D: {lower_c, upper_c} = 16'h5C7C; // \ |
            8'h4C: {lower_c, upper_c} = 16'h3B3A; // ; :
            8'h52: {lower_c, upper_c} = 16'h2722; // ' "
            8'h0E: {lower_c, upper_c} = 16'h607E; // ` ~
            8'h41: {lower_c, upper_c} = 16'h2C3C; // , <
            8'h49: {lower_c, upper_c} = 16'h2E3E; // . >
            8'h4A: {lower_c, upper_c} = 16'h2F3F; // / ?
            default: {lower_c, upper_c} = 16'h0000;
        endcase
    end

    // Letters are recognised from their unshifted character, shift selects the column
    always_comb begin
        is_letter = (lower_c >= 8'h61) && (lower_c <= 8'h7A);
        ascii     = shift ? upper_c : lower_c;
    end

endmodule

// File: rtl/ps2_key_decode.sv
// Turns keyboard FIFO entries into ASCII key events, tracking shift/ctrl/alt
// held state and a caps-lock toggle. One entry is handled per IDLE->LOOKUP->EMIT pass.
module ps2_key_decode
    import ps2_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       in_valid,
    input  logic [9:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_ascii,
    output logic [7:0] out_code,
    output logic       out_ext,
    output logic [3:0] out_mods,
    output logic       caps_lock
);

    state_t     state_q, state_d;
    logic       ready_en_q, ready_en_d;
    logic [9:0] entry_q, entry_d;
    logic       lshift_q, lshift_d, rshift_q, rshift_d;
    logic       lctrl_q, lctrl_d, rctrl_q, rctrl_d;
    logic       lalt_q, lalt_d, ralt_q, ralt_d;
    logic       caps_held_q, caps_held_d, caps_lock_q, caps_lock_d;
    logic [7:0] out_ascii_q, out_ascii_d, out_code_q, out_code_d;
    logic       out_ext_q, out_ext_d;
    logic [3:0] out_mods_q, out_mods_d;

    logic       ent_brk, ent_ext;
    logic [7:0] ent_code;
    logic       shift_c, ctrl_c, alt_c;
    logic       is_resp, is_mod, do_emit;
    logic       map_shift, map_letter;
    logic [7:0] map_ascii;

    assign ent_brk  = entry_q[BREAK_BIT];
    assign ent_ext  = entry_q[EXT_BIT];
    assign ent_code = entry_q[7:0];
    assign shift_c  = lshift_q | rshift_q;
    assign ctrl_c   = lctrl_q | rctrl_q;
    assign alt_c    = lalt_q | ralt_q;

    // Shift and ctrl/alt keys exist on both sides; caps is only tracked non-extended
    assign is_resp = !ent_ext && is_ctrl_resp(ent_code);
    assign is_mod  = (!ent_ext && ((ent_code == SC_LSHIFT) || (ent_code == SC_RSHIFT) ||
                                   (ent_code == SC_CAPS))) ||
                     (ent_code == SC_CTRL) || (ent_code == SC_ALT);
    assign do_emit = !is_resp && !is_mod && !ent_brk;

    // Caps only inverts shift for letters
    assign map_shift = map_letter ? (shift_c ^ caps_lock_q) : shift_c;

    ps2_keymap u_keymap (
        .code      (ent_code),
        .shift     (map_shift),
        .ascii     (map_ascii),
        .is_letter (map_letter)
    );

    // State and datapath registers, cleared immediately by reset
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            ready_en_q  <= 1'b0;
            entry_q     <= '0;
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            lctrl_q     <= 1'b0;
            rctrl_q     <= 1'b0;
            lalt_q      <= 1'b0;
            ralt_q      <= 1'b0;
            caps_held_q <= 1'b0;
            caps_lock_q <= 1'b0;
            out_ascii_q <= '0;
            out_code_q  <= '0;
            out_ext_q   <= 1'b0;
            out_mods_q  <= '0;
        end else begin
            state_q     <= state_d;
            ready_en_q  <= ready_en_d;
            entry_q     <= entry_d;
            lshift_q    <= lshift_d;
            rshift_q    <= rshift_d;
            lctrl_q     <= lctrl_d;
            rctrl_q     <= rctrl_d;
            lalt_q      <= lalt_d;
            ralt_q      <= ralt_d;
            caps_held_q <= caps_held_d;
            caps_lock_q <= caps_lock_d;
            out_ascii_q <= out_ascii_d;
            out_code_q  <= out_code_d;
            out_ext_q   <= out_ext_d;
            out_mods_q  <= out_mods_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (in_valid && in_ready) state_d = S_LOOKUP;
            S_LOOKUP: state_d = do_emit ? S_EMIT : S_IDLE;
            S_EMIT:   if (out_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = ready_en_q && (state_q == S_IDLE);
        out_valid = (state_q == S_EMIT);
        out_ascii = out_ascii_q;
        out_code  = out_code_q;
        out_ext   = out_ext_q;
        out_mods  = out_mods_q;
        caps_lock = caps_lock_q;
    end

    // Entry capture, modifier tracking and event formation during LOOKUP
    always_comb begin
        ready_en_d  = 1'b1;
        entry_d     = entry_q;
        lshift_d    = lshift_q;
        rshift_d    = rshift_q;
        lctrl_d     = lctrl_q;
        rctrl_d     = rctrl_q;
        lalt_d      = lalt_q;
        ralt_d      = ralt_q;
        caps_held_d = caps_held_q;
        caps_lock_d = caps_lock_q;
        out_ascii_d = out_ascii_q;
        out_code_d  = out_code_q;
        out_ext_d   = out_ext_q;
        out_mods_d  = out_mods_q;

        if (in_valid && in_ready) begin
            entry_d = in_data;
        end

        if ((state_q == S_LOOKUP) && !is_resp) begin
            if (is_mod) begin
                if (ent_code == SC_LSHIFT)      lshift_d = !ent_brk;
                else if (ent_code == SC_RSHIFT) rshift_d = !ent_brk;
                else if (ent_code == SC_CTRL) begin
                    if (ent_ext) rctrl_d = !ent_brk;
                    else         lctrl_d = !ent_brk;
                end else if (ent_code == SC_ALT) begin
                    if (ent_ext) ralt_d = !ent_brk;
                    else         lalt_d = !ent_brk;
                end else begin
                    // Typematic repeats of caps arrive as makes while still held
                    if (!ent_brk) begin
                        if (!caps_held_q) caps_lock_d = !caps_lock_q;
                        caps_held_d = 1'b1;
                    end else begin
                        caps_held_d = 1'b0;
                    end
                end
            end else if (do_emit) begin
                out_code_d = ent_code;
                out_ext_d  = ent_ext;
                out_mods_d = {ctrl_c, alt_c, shift_c, caps_lock_q};
                if (ent_ext) begin
                    if (ent_code == SC_ENTER)      out_ascii_d = 8'h0D;
                    else if (ent_code == SC_SLASH) out_ascii_d = 8'h2F;
                    else                           out_ascii_d = 8'h00;
                end else if (ctrl_c && map_letter) begin
                    out_ascii_d = map_ascii & 8'h1F;
                end else begin
                    out_ascii_d = map_ascii;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decode.sv
// Scoreboard bench: a behavioural keyboard model predicts each key event,
// a monitor pops predictions and compares whenever the decoder hands one over.
module tb_ps2_key_decode;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       in_valid;
    logic [9:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_ascii;
    logic [7:0] out_code;
    logic       out_ext;
    logic [3:0] out_mods;
    logic       caps_lock;

    always #5 clk_i = ~clk_i;

    ps2_key_decode dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ascii (out_ascii),
        .out_code  (out_code),
        .out_ext   (out_ext),
        .out_mods  (out_mods),
        .caps_lock (caps_lock)
    );

    typedef struct packed {
        logic [7:0] ascii;
        logic [7:0] code;
        logic       ext;
        logic [3:0] mods;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  bp_mode = 0;  // 0: always ready, 1: random ready, 2: never ready

    // Key tables: letters in alphabetical order, other keys with both characters
    bit [7:0] letter_codes[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                   8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                   8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                   8'h35, 8'h1A};
    bit [7:0] other_codes[26]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                   8'h3E, 8'h46, 8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76, 8'h4E,
                                   8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h0E, 8'h41,
                                   8'h49, 8'h4A};
    bit [7:0] other_lo[26]     = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                                   8'h38, 8'h39, 8'h20, 8'h0D, 8'h08, 8'h09, 8'h1B, 8'h2D,
                                   8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27, 8'h60, 8'h2C,
                                   8'h2E, 8'h2F};
    bit [7:0] other_hi[26]     = '{8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26,
                                   8'h2A, 8'h28, 8'h20, 8'h0D, 8'h08, 8'h09, 8'h1B, 8'h5F,
                                   8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22, 8'h7E, 8'h3C,
                                   8'h3E, 8'h3F};
    bit [7:0] resp_codes[5]    = '{8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF};
    bit [7:0] ext_codes[8]     = '{8'h5A, 8'h4A, 8'h75, 8'h6B, 8'h74, 8'h72, 8'h14, 8'h11};

    // Reference keyboard state
    bit m_lshift, m_rshift, m_lctrl, m_rctrl, m_lalt, m_ralt, m_caps, m_caps_held;

    task automatic model_reset();
        {m_lshift, m_rshift, m_lctrl, m_rctrl, m_lalt, m_ralt, m_caps, m_caps_held} = '0;
    endtask

    task automatic model_apply(input logic [9:0] d);
        bit brk, ext, shift, ctrl, alt, found;
        bit [7:0] code, ch;
        ev_t ev;
        brk = d[9]; ext = d[8]; code = d[7:0];
        shift = m_lshift || m_rshift;
        ctrl  = m_lctrl || m_rctrl;
        alt   = m_lalt || m_ralt;
        if (!ext) begin
            foreach (resp_codes[i]) if (code == resp_codes[i]) return;
            if (code == 8'h12) begin m_lshift = !brk; return; end
            if (code == 8'h59) begin m_rshift = !brk; return; end
            if (code == 8'h58) begin
                if (!brk) begin
                    if (!m_caps_held) m_caps = !m_caps;
                    m_caps_held = 1;
                end else m_caps_held = 0;
                return;
            end
        end
        if (code == 8'h14) begin if (ext) m_rctrl = !brk; else m_lctrl = !brk; return; end
        if (code == 8'h11) begin if (ext) m_ralt = !brk; else m_lalt = !brk; return; end
        if (brk) return;
        ch = 8'h00;
        if (ext) begin
            if (code == 8'h5A) ch = 8'h0D;
            else if (code == 8'h4A) ch = 8'h2F;
        end else begin
            found = 0;
            for (int i = 0; i < 26; i++) begin
                if (letter_codes[i] == code) begin
                    found = 1;
                    if (ctrl)                ch = 8'(i + 1);          // ^A = 1 ... ^Z = 26
                    else if (shift ^ m_caps) ch = 8'(8'h41 + i);
                    else                     ch = 8'(8'h61 + i);
                end
            end
            if (!found)
                for (int i = 0; i < 26; i++)
                    if (other_codes[i] == code) ch = shift ? other_hi[i] : other_lo[i];
        end
        ev.ascii = ch; ev.code = code; ev.ext = ext;
        ev.mods = {ctrl, alt, shift, m_caps};
        exp_q.push_back(ev);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge
    task automatic send(input logic [9:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 100) begin @(negedge clk_i); n++; end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: entry %03h never accepted", d);
            in_valid = 1'b0;
            return;
        end
        model_apply(d);
        @(posedge clk_i);
        @(negedge clk_i);
        in_valid = 1'b0;
        $display("sent entry %03h", d);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin @(negedge clk_i); n++; end
        checks++;
        if (exp_q.size() != 0 || out_valid) begin
            errors++;
            $display("FAIL drain: %0d events still expected, out_valid=%0b", exp_q.size(), out_valid);
        end
    endtask

    // Monitor: drives out_ready, checks hold stability and scores each handshake
    initial begin
        ev_t act, held, e;
        bit  have_held;
        have_held = 0;
        out_ready = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                have_held = 0;
            end else begin
                act = {out_ascii, out_code, out_ext, out_mods};
                if (out_valid && have_held) begin
                    checks++;
                    if (act !== held) begin
                        errors++;
                        $display("FAIL hold_stable: got %06h expected %06h", act, held);
                    end
                end
                case (bp_mode)
                    0:       out_ready = 1'b1;
                    1:       out_ready = ($urandom_range(0, 3) != 0);
                    default: out_ready = 1'b0;
                endcase
                have_held = 0;
                if (out_valid) begin
                    if (!out_ready) begin
                        held = act; have_held = 1;
                    end else if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_event: got ascii %02h code %02h", out_ascii, out_code);
                    end else begin
                        e = exp_q.pop_front();
                        checks++;
                        if (act !== e) begin
                            errors++;
                            $display("FAIL event: got ascii %02h code %02h ext %0b mods %04b expected ascii %02h code %02h ext %0b mods %04b",
                                     act.ascii, act.code, act.ext, act.mods, e.ascii, e.code, e.ext, e.mods);
                        end else
                            $display("event ascii %02h code %02h ext %0b mods %04b ok",
                                     act.ascii, act.code, act.ext, act.mods);
                    end
                end
            end
        end
    end

    initial begin
        logic [9:0] d;
        bit [7:0] c;
        bit e, b;
        int r;
        rst_i = 1'b0; in_valid = 1'b0; in_data = '0;
        model_reset();
        repeat (3) @(negedge clk_i);
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_outs", {out_ascii, out_code, out_ext, out_mods}, 0);
        check("reset_caps", caps_lock, 0);
        rst_i = 1'b1;
        check("in_ready_before_edge", in_ready, 0);
        @(posedge clk_i); #1;
        check("in_ready_after_release", in_ready, 1);
        @(negedge clk_i);

        // Plain 'a', latency, break silent
        send(10'h01C);
        check("latency_lookup", out_valid, 0);
        @(negedge clk_i);
        check("latency_emit", out_valid, 1);
        @(negedge clk_i);
        send(10'h21C);
        drain();

        // Shifted 'A', then unshifted
        send(10'h012); send(10'h01C); send(10'h212); send(10'h01C);
        drain();

        // Caps toggles once despite repeat
        send(10'h058); send(10'h058); send(10'h258);
        check("caps_single_toggle", caps_lock, 1);
        send(10'h01C); send(10'h012); send(10'h01C);
        drain();
        send(10'h212); send(10'h058); send(10'h258);   // caps back off
        check("caps_off", caps_lock, 0);

        // Ctrl letter, extended keys
        send(10'h014); send(10'h021); send(10'h214);
        send(10'h15A); send(10'h175);
        drain();

        // Randomised traffic with random backpressure
        bp_mode = 1;
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 99);
            b = ($urandom_range(0, 99) < 30);
            e = 0;
            if (r < 45)      c = letter_codes[$urandom_range(0, 25)];
            else if (r < 65) c = other_codes[$urandom_range(0, 25)];
            else if (r < 78) begin
                case ($urandom_range(0, 3))
                    0: c = 8'h12;
                    1: c = 8'h59;
                    2: begin c = 8'h14; e = $urandom_range(0, 1) == 1; end
                    default: begin c = 8'h11; e = $urandom_range(0, 1) == 1; end
                endcase
            end
            else if (r < 83) c = 8'h58;
            else if (r < 88) c = resp_codes[$urandom_range(0, 4)];
            else if (r < 94) begin c = ext_codes[$urandom_range(0, 7)]; e = 1; end
            else             c = 8'($urandom_range(0, 255));
            d = {b, e, c};
            send(d);
        end
        drain();
        check("caps_after_random", caps_lock, m_caps);

        // Stall in EMIT, then reset mid-event
        bp_mode = 2;
        send(10'h058);
        send(10'h01C);
        @(negedge clk_i);
        for (int k = 0; k < 5; k++) begin
            check("stall_out_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
            @(negedge clk_i);
        end
        #2 rst_i = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_caps", caps_lock, 0);
        check("rst_outs", {out_ascii, out_code, out_ext, out_mods}, 0);
        check("rst_in_ready", in_ready, 0);
        exp_q.delete();
        model_reset();
        bp_mode = 0;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        check("in_ready_after_rerelease", in_ready, 1);
        @(negedge clk_i);
        send(10'h01C);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

endmodule
